// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch controller: PC, memory read handshake, 8085 length decode
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic        ir_load,
    output logic [7:0]  ir_data,
    output logic [7:0]  operand_lo,
    output logic [7:0]  operand_hi,
    output logic [1:0]  instr_len,
    output logic        instr_valid,
    input  logic        decode_ack,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    output logic [15:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_OP = 3'd1,
        S_FETCH_B2 = 3'd2,
        S_FETCH_B3 = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pc;
    logic [7:0]  r_operand_lo;
    logic [7:0]  r_operand_hi;
    logic [1:0]  r_len;
    logic        r_valid;
    logic        w_mem_rd;
    logic        w_ir_load;
    logic        w_xfer;
    logic        w_pc_load_ok;
    logic [1:0]  w_dec_len;

    function automatic logic [1:0] f_len(input logic [7:0] op);
        case (op)
            8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
            8'hC3, 8'hCD,
            8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2, 8'hFA,
            8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC, 8'hF4, 8'hFC:
                f_len = 2'd3;
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hD3, 8'hDB:
                f_len = 2'd2;
            default:
                f_len = 2'd1;
        endcase
    endfunction

    assign w_dec_len    = f_len(mem_data);
    assign w_xfer       = w_mem_rd & mem_ready;
    // Branch targets are accepted only between instructions, never mid-fetch.
    assign w_pc_load_ok = pc_load & ((r_state == S_IDLE) | ((r_state == S_HOLD) & decode_ack));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (fetch_en) w_state_next = S_FETCH_OP;
            S_FETCH_OP: if (w_xfer) w_state_next = (w_dec_len > 2'd1) ? S_FETCH_B2 : S_HOLD;
            S_FETCH_B2: if (w_xfer) w_state_next = (r_len == 2'd3) ? S_FETCH_B3 : S_HOLD;
            S_FETCH_B3: if (w_xfer) w_state_next = S_HOLD;
            S_HOLD:     if (decode_ack) w_state_next = fetch_en ? S_FETCH_OP : S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_rd  = 1'b0;
        w_ir_load = 1'b0;
        case (r_state)
            S_FETCH_OP: begin
                w_mem_rd  = 1'b1;
                w_ir_load = mem_ready;
            end
            S_FETCH_B2, S_FETCH_B3: w_mem_rd = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_operand_lo <= 8'h00;
            r_operand_hi <= 8'h00;
            r_len        <= 2'd1;
            r_valid      <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_pc <= r_pc + 16'd1;
            end else if (w_pc_load_ok) begin
                r_pc <= pc_load_val;
            end
            if (w_xfer) begin
                case (r_state)
                    S_FETCH_OP: begin
                        r_len        <= w_dec_len;
                        r_operand_lo <= 8'h00;
                        r_operand_hi <= 8'h00;
                    end
                    S_FETCH_B2: r_operand_lo <= mem_data;
                    S_FETCH_B3: r_operand_hi <= mem_data;
                    default: ;
                endcase
            end
            // Valid tracks residency in HOLD, so it rises with the last byte and drops on ack.
            r_valid <= (w_state_next == S_HOLD);
        end
    end

    assign mem_addr    = r_pc;
    assign pc          = r_pc;
    assign mem_rd      = w_mem_rd;
    assign ir_load     = w_ir_load;
    assign ir_data     = mem_data;
    assign operand_lo  = r_operand_lo;
    assign operand_hi  = r_operand_hi;
    assign instr_len   = r_len;
    assign instr_valid = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against an instruction-level reference model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic        ir_load;
    logic [7:0]  ir_data;
    logic [7:0]  operand_lo;
    logic [7:0]  operand_hi;
    logic [1:0]  instr_len;
    logic        instr_valid;
    logic        decode_ack;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] pc;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    localparam logic [7:0] OPS3 [26] = '{
        8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCD,
        8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2, 8'hFA,
        8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC, 8'hF4, 8'hFC};
    localparam logic [7:0] OPS2 [18] = '{
        8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
        8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hD3, 8'hDB};

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_data(mem_data),
        .ir_load(ir_load), .ir_data(ir_data),
        .operand_lo(operand_lo), .operand_hi(operand_hi), .instr_len(instr_len),
        .instr_valid(instr_valid), .decode_ack(decode_ack),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .pc(pc));

    function automatic int ref_len(input logic [7:0] op);
        for (int i = 0; i < 26; i++) if (OPS3[i] == op) return 3;
        for (int i = 0; i < 18; i++) if (OPS2[i] == op) return 2;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        mem_data = mem[mem_addr];
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pc"}, 32'(pc), 32'h0000);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'h0000);
        chk({tag, " mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, " ir_load"}, 32'(ir_load), 32'd0);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, " operand_lo"}, 32'(operand_lo), 32'd0);
        chk({tag, " operand_hi"}, 32'(operand_hi), 32'd0);
        chk({tag, " instr_len"}, 32'(instr_len), 32'd1);
    endtask

    // waits < 0 : random wait states; noise : hold pc_load high and toggle decode_ack while fetching
    task automatic fetch_one(input string tag, input logic [15:0] start, input int pre,
                             input int loads_exp, input int waits, input bit noise, input int rd_exp);
        int          len, loads, xfers, rd, wl, cyc, last_x;
        logic [15:0] a1, a2;
        len = ref_len(mem[start]);
        a1 = start + 16'd1;
        a2 = start + 16'd2;
        loads = 0; xfers = 0; rd = 0; wl = waits; cyc = 0; last_x = -10;
        while (!instr_valid && cyc < 200) begin
            pc_load = 1'b0;
            decode_ack = 1'b0;
            if (mem_rd) begin
                if (waits < 0) mem_ready = ($urandom_range(0, 2) != 0);
                else if (wl > 0) begin mem_ready = 1'b0; wl--; end
                else begin mem_ready = 1'b1; wl = waits; end
                if (noise) begin
                    pc_load = 1'b1;
                    pc_load_val = 16'($urandom);
                    decode_ack = 1'($urandom_range(0, 1));
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (mem_rd) rd++;
            if (mem_rd && mem_ready) begin xfers++; last_x = cyc; end
            if (ir_load) begin
                loads++;
                chk({tag, " ir_data"}, 32'(ir_data), 32'(mem[start]));
                chk({tag, " opcode addr"}, 32'(mem_addr), 32'(start));
            end
            if (rd > 0) chk({tag, " mem_rd held"}, 32'(mem_rd), 32'd1);
            cycle();
            cyc++;
        end
        pc_load = 1'b0;
        decode_ack = 1'b0;
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, " byte count"}, 32'(xfers), 32'(len - pre));
        chk({tag, " valid latency"}, 32'(cyc - last_x), 32'd1);
        chk({tag, " ir_load count"}, 32'(loads), 32'(loads_exp));
        if (rd_exp > 0) chk({tag, " read cycles"}, 32'(rd), 32'(rd_exp));
        chk({tag, " instr_len"}, 32'(instr_len), 32'(len));
        chk({tag, " operand_lo"}, 32'(operand_lo), (len > 1) ? 32'(mem[a1]) : 32'd0);
        chk({tag, " operand_hi"}, 32'(operand_hi), (len > 2) ? 32'(mem[a2]) : 32'd0);
        exp_pc = start + 16'(len);
        chk({tag, " pc"}, 32'(pc), 32'(exp_pc));
    endtask

    task automatic hold_ack(input string tag, input bit ld, input logic [15:0] val, input bit fen);
        decode_ack = 1'b1;
        pc_load = ld;
        pc_load_val = val;
        fetch_en = fen;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk({tag, " hold mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, " hold ir_load"}, 32'(ir_load), 32'd0);
        cycle();
        decode_ack = 1'b0;
        pc_load = 1'b0;
        if (ld) exp_pc = val;
        #1;
        chk({tag, " valid cleared"}, 32'(instr_valid), 32'd0);
        chk({tag, " pc after ack"}, 32'(pc), 32'(exp_pc));
        chk({tag, " mem_rd after ack"}, 32'(mem_rd), 32'(fen));
    endtask

    initial begin
        bit          in_idle;
        bit          ld;
        bit          fen;
        logic [15:0] val;

        foreach (mem[i]) mem[i] = 8'($urandom);
        mem[16'h0000] = 8'h3E; mem[16'h0001] = 8'h5A; mem[16'h0002] = 8'h00;
        mem[16'h0010] = 8'hC3; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
        mem[16'h1234] = 8'h3A; mem[16'h1235] = 8'hAA; mem[16'h1236] = 8'hBB;
        mem[16'hFFFF] = 8'h76;
        mem[16'h0100] = 8'hCD; mem[16'h0101] = 8'h11; mem[16'h0102] = 8'h22;
        mem[16'h0200] = 8'h06; mem[16'h0201] = 8'h77;

        reset = 1'b1; fetch_en = 1'b1; mem_ready = 1'b1; decode_ack = 1'b0;
        pc_load = 1'b0; pc_load_val = 16'h0000; mem_data = 8'h00;
        repeat (2) cycle();
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        exp_pc = 16'h0000;

        fetch_one("mvi", 16'h0000, 0, 1, 0, 0, 2);
        pc_load = 1'b1;
        pc_load_val = 16'hBEEF;
        repeat (3) begin
            mem_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        pc_load = 1'b0;
        #1;
        chk("hold no ack pc", 32'(pc), 32'h0002);
        chk("hold no ack valid", 32'(instr_valid), 32'd1);
        chk("hold no ack mem_rd", 32'(mem_rd), 32'd0);

        hold_ack("to 0010", 1'b1, 16'h0010, 1'b1);
        fetch_one("jmp waits", 16'h0010, 0, 1, 2, 0, 9);

        hold_ack("to 1234", 1'b1, 16'h1234, 1'b1);
        chk("branch mem_addr", 32'(mem_addr), 32'h1234);
        fetch_one("lda pc_load ignored", 16'h1234, 0, 1, 0, 1, 3);

        hold_ack("to FFFF", 1'b1, 16'hFFFF, 1'b1);
        fetch_one("hlt wrap", 16'hFFFF, 0, 1, 0, 0, 1);

        hold_ack("to 0100", 1'b1, 16'h0100, 1'b1);
        mem_ready = 1'b1;
        cycle();
        cycle();
        #1;
        chk("pre-reset mem_rd", 32'(mem_rd), 32'd1);
        chk("pre-reset valid", 32'(instr_valid), 32'd0);
        chk("pre-reset pc", 32'(pc), 32'h0102);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midfetch reset");
        cycle();
        reset = 1'b0;
        mem_data = mem[mem_addr];
        exp_pc = 16'h0000;
        fetch_one("refetch", 16'h0000, 0, 1, 0, 0, 2);

        hold_ack("to 0200", 1'b1, 16'h0200, 1'b1);
        mem_ready = 1'b1;
        cycle();
        fetch_en = 1'b0;
        fetch_one("fetch_en drop", 16'h0200, 1, 0, 0, 0, 1);
        hold_ack("to idle", 1'b0, 16'h0000, 1'b0);
        decode_ack = 1'b1;
        repeat (2) cycle();
        decode_ack = 1'b0;
        #1;
        chk("idle mem_rd", 32'(mem_rd), 32'd0);
        chk("idle valid", 32'(instr_valid), 32'd0);
        chk("idle pc", 32'(pc), 32'h0202);

        in_idle = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (in_idle) begin
                repeat ($urandom_range(0, 3)) begin
                    fetch_en = 1'b0;
                    pc_load = 1'($urandom_range(0, 1));
                    pc_load_val = 16'($urandom);
                    mem_ready = 1'($urandom_range(0, 1));
                    #1;
                    chk("rand idle mem_rd", 32'(mem_rd), 32'd0);
                    if (pc_load) exp_pc = pc_load_val;
                    cycle();
                end
                fetch_en = 1'b1;
                pc_load = 1'($urandom_range(0, 1));
                pc_load_val = 16'($urandom);
                if (pc_load) exp_pc = pc_load_val;
                cycle();
                pc_load = 1'b0;
            end
            fetch_one("rand", exp_pc, 0, 1, -1, 1, 0);
            ld = 1'($urandom_range(0, 1));
            fen = 1'($urandom_range(0, 1));
            val = 16'($urandom);
            hold_ack("rand ack", ld, val, fen);
            in_idle = !fen;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch controller directly upstream of the instruction register. It owns the 16-bit program counter and runs the memory read handshake. It fetches the opcode byte, driving the instruction register load strobe and data, then fetches the 0–2 operand bytes that 8085-style length decoding requires. It presents the complete instruction to the decoder and holds it until the decoder acknowledges.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk` in 1: single system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `fetch_en` in 1: permits new instruction fetches.
- `mem_addr` out 16: read address (= `pc` while reading).
- `mem_rd` out 1: read request.
- `mem_ready` in 1: memory has data valid on `mem_data` this cycle.
- `mem_data` in 8: read data.
- `ir_load` out 1: opcode strobe to instruction register (combinational).
- `ir_data` out 8: opcode byte to instruction register (combinational, = `mem_data`).
- `operand_lo` out 8: byte 2 of current instruction.
- `operand_hi` out 8: byte 3 of current instruction.
- `instr_len` out 2: length of current instruction, 1..3.
- `instr_valid` out 1: current instruction complete and held.
- `decode_ack` in 1: decoder has consumed current instruction.
- `pc_load` in 1: branch/jump request.
- `pc_load_val` in 16: branch target.
- `pc` out 16: program counter.

## Operation
- States: IDLE, FETCH_OP, FETCH_B2, FETCH_B3, HOLD.
- `mem_rd` = 1 exactly in FETCH_OP/FETCH_B2/FETCH_B3; `mem_addr` = `pc` always.
- A byte transfers on any rising edge where `mem_rd`=1 and `mem_ready`=1. On that edge `pc` <= `pc`+1, wrapping 16'hFFFF -> 16'h0000. Wait states (`mem_ready`=0) hold state and `pc` indefinitely.
- IDLE: if `fetch_en` -> FETCH_OP.
- FETCH_OP: `ir_load` = `mem_ready`. On transfer:
  - latch `instr_len` from `mem_data`;
  - clear `operand_lo`/`operand_hi` to 0;
  - go to FETCH_B2 if len>1, else HOLD.
- FETCH_B2: on transfer, `operand_lo` <= `mem_data`; go to FETCH_B3 if len=3, else HOLD.
- FETCH_B3: on transfer, `operand_hi` <= `mem_data`; go to HOLD.
- HOLD: `instr_valid`=1 (registered, set on the edge entering HOLD). On `decode_ack`: clear `instr_valid`; go to FETCH_OP if `fetch_en`, else IDLE.
- `pc_load` is honoured only in IDLE, or in HOLD together with `decode_ack`: `pc` <= `pc_load_val` (no increment). It is ignored in fetch states and in HOLD without ack.
- Length decode:
  - 3 bytes: 01,11,21,31, 22,2A,32,3A, C3, CD, C2,CA,D2,DA,E2,EA,F2,FA, C4,CC,D4,DC,E4,EC,F4,FC.
  - 2 bytes: 06,0E,16,1E,26,2E,36,3E, C6,CE,D6,DE,E6,EE,F6,FE, D3,DB.
  - All other opcodes: 1 byte.
- Deasserting `fetch_en` mid-instruction does not abort the fetch; it takes effect only at the IDLE/HOLD decision.

## Timing
- Reset (async, immediate):
  - state IDLE, `pc`=`RESET_PC`;
  - `mem_rd`=0, `ir_load`=0, `instr_valid`=0;
  - `operand_lo`=`operand_hi`=0, `instr_len`=2'd1.
- Reset mid-fetch abandons the instruction; no partial `instr_valid`.
- Zero-wait memory: 1-byte instruction reaches HOLD 1 edge after entering FETCH_OP, 2-byte 2 edges, 3-byte 3 edges.
- `instr_valid` rises on the edge that captures the last byte.
- With `decode_ack` and `fetch_en` high, back-to-back instructions have 1 dead cycle (HOLD) between the last byte of one and `mem_rd` of the next.
- `ir_load` is high for exactly one cycle per instruction when `mem_ready` is held high. With wait states it is high only in the transfer cycle.
- `decode_ack` outside HOLD is ignored.

## Test plan
- Reset with `RESET_PC`=16'h0000, `fetch_en`=1, memory {00:3E, 01:5A, 02:00}, zero wait -> `ir_load` pulse with `ir_data`=3E at pc 0000; HOLD with `instr_len`=2, `operand_lo`=5A, `operand_hi`=00, `pc`=0002.
- 3-byte C3 34 12 at 0010, `mem_ready` low 2 cycles per byte -> `mem_rd` held through waits; `instr_valid` after 9 cycles; `operand_lo`=34, `operand_hi`=12, `pc`=0013.
- In HOLD after the C3, `decode_ack`+`pc_load`, `pc_load_val`=1234 -> next fetch at `mem_addr`=1234; `pc_load` pulsed during FETCH_B2 of another instruction -> ignored.
- 1-byte 76 at FFFF -> `instr_len`=1, `pc` wraps to 0000.
- Assert `reset` during FETCH_B3 -> all outputs at reset values immediately, no `instr_valid`; refetch from `RESET_PC` after release.
- `fetch_en` dropped during FETCH_B2 -> instruction completes; after `decode_ack`, state IDLE, `mem_rd`=0.
